mac_result_drain: RTL and testbench

//  Sequencer and result reader for the MxM MAC array.
//  - On start, holds the array's enable high for K cycles, waits for the pipeline to settle,

---
 rtl/mac_result_drain_if.sv | 18 +
 rtl/mac_result_drain.sv | 164 ++++++++++++++++
 tb/tb_mac_result_drain.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_result_drain_if.sv
// Result stream between the MAC drain sequencer and the output/DMA path.
// Signals:
//   m_tdata   result word (row-major index i*M+j)
//   m_tvalid  m_tdata valid
//   m_tready  downstream ready
//   m_tlast   marks the final word of a job
// Modports: master (drain side), slave (consumer side).
interface mac_result_drain_if #(
    parameter int unsigned OUT_WIDTH = 32
);
    logic [OUT_WIDTH-1:0] m_tdata;
    logic                 m_tvalid;
    logic                 m_tready;
    logic                 m_tlast;

    modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
    modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/mac_result_drain.sv
// Sequencer and result reader for the MxM MAC array.
// Runs the array for k_len enabled cycles, waits PIPE_LAT cycles for the
// pipeline to settle, snapshots the whole accumulator grid in one cycle and
// streams it out row-major as M*M words with last on the final word.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        job request pulse, accepted only when idle
//   k_len        accumulate steps, sampled with an accepted start
//   mac_en       enable to the MAC array
//   acc          signed [M][M] accumulator grid from the array
//   strm         result stream (master side of mac_result_drain_if)
//   busy         high while a job is in progress
//   done         one-cycle pulse after the last word is accepted
// Build option: define MAC_DRAIN_SAT_EN to saturate each word to the signed
// OUT_WIDTH range; otherwise words are truncated to their low OUT_WIDTH bits.
module mac_result_drain #(
    parameter int unsigned M         = 4,
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned K_WIDTH   = 16,
    parameter int unsigned PIPE_LAT  = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [K_WIDTH-1:0]                    k_len,
    output logic                                  mac_en,
    input  logic [M-1:0][M-1:0][ACC_WIDTH-1:0]    acc,
    mac_result_drain_if.master                    strm,
    output logic                                  busy,
    output logic                                  done
);

    localparam int unsigned WORDS = M * M;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned LAT_W = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

`ifdef MAC_DRAIN_SAT_EN
    localparam logic [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    state_t                            state;
    logic [K_WIDTH-1:0]                k_cnt;
    logic [LAT_W-1:0]                  lat_cnt;
    logic [IDX_W-1:0]                  idx;
    logic [IDX_W-1:0]                  idx_nxt;
    logic [WORDS-1:0][ACC_WIDTH-1:0]   snap;

    // Narrow a full-width accumulator word to the stream width.
    function automatic logic [OUT_WIDTH-1:0] narrow(input logic [ACC_WIDTH-1:0] v);
`ifdef MAC_DRAIN_SAT_EN
        if ($signed(v) > $signed(SAT_MAX)) begin
            return SAT_MAX[OUT_WIDTH-1:0];
        end
        if ($signed(v) < $signed(SAT_MIN)) begin
            return SAT_MIN[OUT_WIDTH-1:0];
        end
        return v[OUT_WIDTH-1:0];
`else
        logic unused_hi;
        unused_hi = ^v;
        return v[OUT_WIDTH-1:0];
`endif
    endfunction

    assign idx_nxt = idx + IDX_W'(1);

    // Job sequencer, snapshot and stream output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            k_cnt         <= '0;
            lat_cnt       <= '0;
            idx           <= '0;
            snap          <= '0;
            mac_en        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            strm.m_tdata  <= '0;
            strm.m_tvalid <= 1'b0;
            strm.m_tlast  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (k_len != '0) begin
                            state  <= RUN;
                            k_cnt  <= k_len;
                            mac_en <= 1'b1;
                        end else if (PIPE_LAT != 0) begin
                            state   <= SETTLE;
                            lat_cnt <= LAT_W'(PIPE_LAT);
                        end else begin
                            state <= CAPTURE;
                        end
                    end
                end
                // mac_en was raised on entry; drop it after k_len cycles.
                RUN: begin
                    if (k_cnt == K_WIDTH'(1)) begin
                        mac_en <= 1'b0;
                        if (PIPE_LAT != 0) begin
                            state   <= SETTLE;
                            lat_cnt <= LAT_W'(PIPE_LAT);
                        end else begin
                            state <= CAPTURE;
                        end
                    end else begin
                        k_cnt <= k_cnt - K_WIDTH'(1);
                    end
                end
                SETTLE: begin
                    if (lat_cnt == LAT_W'(1)) begin
                        state <= CAPTURE;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                // Whole grid captured at once; word 0 is loaded straight from acc.
                CAPTURE: begin
                    snap          <= acc;
                    idx           <= '0;
                    strm.m_tdata  <= narrow(acc[0][0]);
                    strm.m_tlast  <= (WORDS == 1);
                    strm.m_tvalid <= 1'b1;
                    state         <= DRAIN;
                end
                DRAIN: begin
                    if (strm.m_tvalid && strm.m_tready) begin
                        if (idx == LAST_IDX) begin
                            strm.m_tvalid <= 1'b0;
                            strm.m_tlast  <= 1'b0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            state         <= IDLE;
                        end else begin
                            idx          <= idx_nxt;
                            strm.m_tdata <= narrow(snap[idx_nxt]);
                            strm.m_tlast <= (idx_nxt == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_result_drain.sv
// Self-checking bench for mac_result_drain: behavioural MAC array driving acc,
// stream collector at the falling edge, per-scenario check tasks.
module tb_mac_result_drain;

    localparam int unsigned M  = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned OW = 16;
    localparam int unsigned KW = 16;
    localparam int unsigned PL = 1;
    localparam int NW = M * M;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic [KW-1:0] k_len;
    logic mac_en;
    logic busy;
    logic done;
    logic [M-1:0][M-1:0][AW-1:0] acc;

    mac_result_drain_if #(.OUT_WIDTH(OW)) s_if ();

    mac_result_drain #(
        .M(M), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .K_WIDTH(KW), .PIPE_LAT(PL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
        .mac_en(mac_en), .acc(acc), .strm(s_if), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural MAC array: one multiply-accumulate per enabled cycle.
    int a_g[M][M];
    int b_g[M][M];
    int ovr[M][M];
    logic ovr_en;
    logic clr;
    logic [AW-1:0] acc_reg[M][M];
    always @(posedge clk) begin
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++)
                if (clr) acc_reg[i][j] <= '0;
                else if (mac_en) acc_reg[i][j] <= acc_reg[i][j] + AW'(a_g[i][j] * b_g[i][j]);
    end
    always_comb begin
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++)
                acc[i][j] = ovr_en ? AW'(ovr[i][j]) : acc_reg[i][j];
    end

    // Reference: expected grid content plus narrowing rule.
    longint exp_grid[M][M];

    function automatic logic [OW-1:0] ref_word(input longint v);
        longint lim;
        longint m;
        lim = longint'(1) << (OW - 1);
`ifdef MAC_DRAIN_SAT_EN
        m = v;
        if (v > lim - 1) m = lim - 1;
        if (v < -lim) m = -lim;
        return OW'(m);
`else
        m = v % (2 * lim);
        if (m < 0) m = m + 2 * lim;
        return OW'(m);
`endif
    endfunction

    // Stream collector / ready driver.
    int rdy_mode = 0;
    logic [OW-1:0] word_q[$];
    bit last_q[$];
    int wcyc_q[$];
    int men_q[$];
    int done_q[$];
    int hold_viol = 0;
    bit stall_prev = 0;
    logic [OW-1:0] data_prev;
    logic last_prev;

    initial begin
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0: s_if.m_tready = 1'b1;
                1: s_if.m_tready = ~cyc[0];
                default: s_if.m_tready = 1'($urandom_range(1));
            endcase
            if (rst_n === 1'b1) begin
                if (stall_prev && (s_if.m_tvalid !== 1'b1 || s_if.m_tdata !== data_prev ||
                                   s_if.m_tlast !== last_prev))
                    hold_viol++;
                if (s_if.m_tvalid === 1'b1 && s_if.m_tready) begin
                    word_q.push_back(s_if.m_tdata);
                    last_q.push_back(s_if.m_tlast);
                    wcyc_q.push_back(cyc);
                end
                if (mac_en === 1'b1) men_q.push_back(cyc);
                if (done === 1'b1) done_q.push_back(cyc);
            end
            stall_prev = (rst_n === 1'b1) && (s_if.m_tvalid === 1'b1) && !s_if.m_tready;
            data_prev  = s_if.m_tdata;
            last_prev  = s_if.m_tlast;
        end
    end

    task automatic clear_logs();
        word_q.delete(); last_q.delete(); wcyc_q.delete();
        men_q.delete(); done_q.delete(); hold_viol = 0;
    endtask

    task automatic clear_array();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        for (int i = 0; i < M; i++) for (int j = 0; j < M; j++) exp_grid[i][j] = 0;
    endtask

    task automatic account(input int k);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++)
                exp_grid[i][j] += longint'(k) * a_g[i][j] * b_g[i][j];
    endtask

    // Issue one job and wait (bounded) for its done pulse.
    task automatic run_job(input int k, input bit extra, output int c0, output bit to);
        clear_logs();
        @(negedge clk); #1;
        start = 1'b1; k_len = KW'(k); c0 = cyc;
        @(negedge clk); #1;
        start = 1'b0;
        to = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk); #1;
            if (done_q.size() != 0) begin to = 1'b0; break; end
            if (extra && (cyc == c0 + 2 || word_q.size() == 3)) begin
                start = 1'b1; k_len = KW'(k + 5);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (to) begin errors++; $display("FAIL job_timeout got no done want done k=%0d", k); end
        account(k);
    endtask

    task automatic test_reset();
        checks++;
        if (mac_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl got %b%b%b want 000", mac_en, busy, done);
        end
        checks++;
        if (s_if.m_tvalid !== 1'b0 || s_if.m_tlast !== 1'b0 || s_if.m_tdata !== '0) begin
            errors++; $display("FAIL reset_stream got %b%b%h want 000", s_if.m_tvalid, s_if.m_tlast, s_if.m_tdata);
        end
    endtask

    task automatic test_basic();
        int c0; bit to; logic [OW-1:0] ew;
        clear_array();
        for (int i = 0; i < M; i++) for (int j = 0; j < M; j++) begin a_g[i][j] = 1; b_g[i][j] = 2; end
        rdy_mode = 0;
        run_job(4, 1'b0, c0, to);
        checks++;
        if (men_q.size() != 4 || men_q[0] != c0 + 1 || men_q[men_q.size()-1] != c0 + 4) begin
            errors++; $display("FAIL basic_mac_en got %0d cycles want 4 from %0d", men_q.size(), c0 + 1);
        end
        checks++;
        if (word_q.size() != NW) begin errors++; $display("FAIL basic_count got %0d want %0d", word_q.size(), NW); end
        for (int n = 0; n < word_q.size() && n < NW; n++) begin
            ew = 16'd8;
            checks++;
            if (word_q[n] !== ew || last_q[n] !== (n == NW - 1)) begin
                errors++; $display("FAIL basic_word%0d got %h/%b want %h/%b", n, word_q[n], last_q[n], ew, n == NW - 1);
            end
        end
        checks++;
        if (wcyc_q.size() == 0 || wcyc_q[0] != c0 + 4 + PL + 2 || wcyc_q[wcyc_q.size()-1] != wcyc_q[0] + NW - 1) begin
            errors++; $display("FAIL basic_timing got first %0d want %0d back-to-back", wcyc_q.size() ? wcyc_q[0] : -1, c0 + 4 + PL + 2);
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != c0 + 4 + PL + NW + 2) begin
            errors++; $display("FAIL basic_done got %0d pulses at %0d want 1 at %0d", done_q.size(), done_q.size() ? done_q[0] : -1, c0 + 4 + PL + NW + 2);
        end
    endtask

    task automatic test_toggle_ready();
        int c0; bit to;
        clear_array();
        for (int i = 0; i < M; i++) for (int j = 0; j < M; j++) begin a_g[i][j] = i * M + j; b_g[i][j] = 1; end
        rdy_mode = 1;
        run_job(1, 1'b0, c0, to);
        checks++;
        if (word_q.size() != NW) begin errors++; $display("FAIL toggle_count got %0d want %0d", word_q.size(), NW); end
        for (int n = 0; n < word_q.size() && n < NW; n++) begin
            checks++;
            if (word_q[n] !== OW'(n) || last_q[n] !== (n == NW - 1)) begin
                errors++; $display("FAIL toggle_word%0d got %h/%b want %h", n, word_q[n], last_q[n], OW'(n));
            end
        end
        checks++;
        if (hold_viol != 0) begin errors++; $display("FAIL toggle_hold got %0d violations want 0", hold_viol); end
        checks++;
        if (done_q.size() != 1 || wcyc_q.size() == 0 || done_q[0] != wcyc_q[wcyc_q.size()-1] + 1) begin
            errors++; $display("FAIL toggle_done got %0d pulses want 1 after last word", done_q.size());
        end
        rdy_mode = 0;
    endtask

    task automatic test_ignore_start();
        int c0; bit to; logic [OW-1:0] ew;
        clear_array();
        for (int i = 0; i < M; i++) for (int j = 0; j < M; j++) begin
            a_g[i][j] = int'($urandom_range(20)) - 10; b_g[i][j] = int'($urandom_range(20)) - 10;
        end
        rdy_mode = 0;
        run_job(4, 1'b1, c0, to);
        checks++;
        if (men_q.size() != 4) begin errors++; $display("FAIL ignore_mac_en got %0d want 4", men_q.size()); end
        checks++;
        if (word_q.size() != NW || done_q.size() != 1) begin
            errors++; $display("FAIL ignore_count got %0d words %0d dones want %0d/1", word_q.size(), done_q.size(), NW);
        end
        for (int n = 0; n < word_q.size() && n < NW; n++) begin
            ew = ref_word(exp_grid[n / M][n % M]);
            checks++;
            if (word_q[n] !== ew) begin errors++; $display("FAIL ignore_word%0d got %h want %h", n, word_q[n], ew); end
        end
        // Zero-length job: array untouched, previous results drained again.
        run_job(0, 1'b0, c0, to);
        checks++;
        if (men_q.size() != 0) begin errors++; $display("FAIL k0_mac_en got %0d want 0", men_q.size()); end
        checks++;
        if (wcyc_q.size() == 0 || wcyc_q[0] != c0 + PL + 2) begin
            errors++; $display("FAIL k0_timing got %0d want %0d", wcyc_q.size() ? wcyc_q[0] : -1, c0 + PL + 2);
        end
        checks++;
        if (word_q.size() != NW) begin errors++; $display("FAIL k0_count got %0d want %0d", word_q.size(), NW); end
        for (int n = 0; n < word_q.size() && n < NW; n++) begin
            ew = ref_word(exp_grid[n / M][n % M]);
            checks++;
            if (word_q[n] !== ew) begin errors++; $display("FAIL k0_word%0d got %h want %h", n, word_q[n], ew); end
        end
    endtask

    task automatic test_reset_mid_job();
        int c0; bit to; logic [OW-1:0] ew; bit got;
        clear_array();
        for (int i = 0; i < M; i++) for (int j = 0; j < M; j++) begin
            a_g[i][j] = int'($urandom_range(30)); b_g[i][j] = int'($urandom_range(30));
        end
        rdy_mode = 0;
        clear_logs();
        @(negedge clk); #1; start = 1'b1; k_len = KW'(3);
        @(negedge clk); #1; start = 1'b0;
        account(3);
        got = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk); #1;
            if (word_q.size() >= 6) begin got = 1'b1; break; end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL abort_wait got %0d words want 6", word_q.size()); end
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        checks++;
        if (s_if.m_tvalid !== 1'b0 || busy !== 1'b0 || mac_en !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_outputs got v%b b%b e%b d%b want 0000", s_if.m_tvalid, busy, mac_en, done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (done_q.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_no_done got %0d pulses busy %b want 0/0", done_q.size(), busy);
        end
        run_job(0, 1'b0, c0, to);
        checks++;
        if (word_q.size() != NW) begin errors++; $display("FAIL restart_count got %0d want %0d", word_q.size(), NW); end
        for (int n = 0; n < word_q.size() && n < NW; n++) begin
            ew = ref_word(exp_grid[n / M][n % M]);
            checks++;
            if (word_q[n] !== ew || last_q[n] !== (n == NW - 1)) begin
                errors++; $display("FAIL restart_word%0d got %h want %h", n, word_q[n], ew);
            end
        end
    endtask

    task automatic test_narrowing();
        int c0; bit to; logic [OW-1:0] ew; logic [OW-1:0] pos_w; logic [OW-1:0] neg_w;
        for (int i = 0; i < M; i++) for (int j = 0; j < M; j++) begin
            ovr[i][j] = ((i * M + j) % 2 == 0) ? 40000 : -40000;
            exp_grid[i][j] = ovr[i][j];
        end
        ovr_en = 1'b1;
        rdy_mode = 0;
        run_job(0, 1'b0, c0, to);
`ifdef MAC_DRAIN_SAT_EN
        pos_w = 16'h7FFF; neg_w = 16'h8000;
`else
        pos_w = 16'h9C40; neg_w = 16'h63C0;
`endif
        checks++;
        if (word_q.size() < 2 || word_q[0] !== pos_w || word_q[1] !== neg_w) begin
            errors++; $display("FAIL narrow_const got %h %h want %h %h", word_q.size() > 0 ? word_q[0] : '0,
                               word_q.size() > 1 ? word_q[1] : '0, pos_w, neg_w);
        end
        for (int n = 0; n < word_q.size() && n < NW; n++) begin
            ew = ref_word(exp_grid[n / M][n % M]);
            checks++;
            if (word_q[n] !== ew) begin errors++; $display("FAIL narrow_word%0d got %h want %h", n, word_q[n], ew); end
        end
        ovr_en = 1'b0;
        // Array contents were hidden, not replaced.
        clear_array();
    endtask

    task automatic test_random_jobs();
        int c0; bit to; int k; logic [OW-1:0] ew;
        clear_array();
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < M; i++) for (int j = 0; j < M; j++) begin
                a_g[i][j] = int'($urandom_range(600)) - 300; b_g[i][j] = int'($urandom_range(600)) - 300;
            end
            k = int'($urandom_range(6));
            rdy_mode = int'($urandom_range(2));
            run_job(k, 1'b0, c0, to);
            checks++;
            if (men_q.size() != k || word_q.size() != NW || done_q.size() != 1 || hold_viol != 0) begin
                errors++; $display("FAIL rand%0d_shape got en%0d w%0d d%0d h%0d want en%0d w%0d d1 h0",
                                   t, men_q.size(), word_q.size(), done_q.size(), hold_viol, k, NW);
            end
            for (int n = 0; n < word_q.size() && n < NW; n++) begin
                ew = ref_word(exp_grid[n / M][n % M]);
                checks++;
                if (word_q[n] !== ew || last_q[n] !== (n == NW - 1)) begin
                    errors++; $display("FAIL rand%0d_word%0d got %h/%b want %h", t, n, word_q[n], last_q[n], ew);
                end
            end
        end
        rdy_mode = 0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; k_len = '0; clr = 1'b1; ovr_en = 1'b0;
        for (int i = 0; i < M; i++) for (int j = 0; j < M; j++) begin
            a_g[i][j] = 0; b_g[i][j] = 0; ovr[i][j] = 0; exp_grid[i][j] = 0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1; clr = 1'b0;
        @(negedge clk);
        test_basic();
        test_toggle_ready();
        test_ignore_start();
        test_reset_mid_job();
        test_narrowing();
        test_random_jobs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
